// File: rtl/uart_time_reporter.sv
// Sends a snapshot of the BCD time as "HH:MM:SS[CR]LF" to UART_tx, one byte per start/done handshake.
// Optional feature: define UART_REPORT_CRLF_EN to terminate with CR LF instead of LF alone.
module uart_time_reporter #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0]  SEP_CHAR    = 8'h3A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       report_req_i,
  input  logic [7:0] hour_bcd_i,
  input  logic [7:0] min_bcd_i,
  input  logic [7:0] sec_bcd_i,
  input  logic       tx_busy_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       rpt_busy_o,
  output logic       rpt_done_o,
  output logic       rpt_err_o
);

`ifdef UART_REPORT_CRLF_EN
  localparam int unsigned MSG_LEN = 10;
`else
  localparam int unsigned MSG_LEN = 9;
`endif
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    IDX_LAST = 4'(MSG_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_IDLE} state_t;

  state_t        state_q;
  logic [3:0]    idx_q;
  logic          pending_q;
  logic [7:0]    hour_q, min_q, sec_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    byte_d;

  function automatic logic [7:0] digit(input logic [3:0] n);
    return (n <= 4'd9) ? {4'h3, n} : 8'h3F;
  endfunction

  // LF is the default so the last index maps to it in both terminator builds
  always_comb begin
    byte_d = 8'h0A;
    case (idx_q)
      4'd0:    byte_d = digit(hour_q[7:4]);
      4'd1:    byte_d = digit(hour_q[3:0]);
      4'd2:    byte_d = SEP_CHAR;
      4'd3:    byte_d = digit(min_q[7:4]);
      4'd4:    byte_d = digit(min_q[3:0]);
      4'd5:    byte_d = SEP_CHAR;
      4'd6:    byte_d = digit(sec_q[7:4]);
      4'd7:    byte_d = digit(sec_q[3:0]);
`ifdef UART_REPORT_CRLF_EN
      4'd8:    byte_d = 8'h0D;
`endif
      default: byte_d = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      timer_q    <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
      rpt_busy_o <= 1'b0;
      rpt_done_o <= 1'b0;
      rpt_err_o  <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      rpt_done_o <= 1'b0;
      rpt_err_o  <= 1'b0;
      if (report_req_i && rpt_busy_o) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (report_req_i || pending_q) begin
            hour_q     <= hour_bcd_i;
            min_q      <= min_bcd_i;
            sec_q      <= sec_bcd_i;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            rpt_busy_o <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          tx_data_o  <= byte_d;
          tx_start_o <= 1'b1;
          timer_q    <= '0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE, WAIT_IDLE: begin
          if (timer_q == TMO_LAST) begin
            // abort drops any queued request as well
            rpt_err_o  <= 1'b1;
            rpt_busy_o <= 1'b0;
            pending_q  <= 1'b0;
            state_q    <= IDLE;
          end else if (state_q == WAIT_DONE) begin
            timer_q <= timer_q + 1'b1;
            if (tx_done_i) state_q <= WAIT_IDLE;
          end else if (!tx_done_i && !tx_busy_i) begin
            if (idx_q == IDX_LAST) begin
              rpt_done_o <= 1'b1;
              rpt_busy_o <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ISSUE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Scoreboard bench for uart_time_reporter with a behavioural UART_tx responder.
`timescale 1ns/1ps
module tb_uart_time_reporter;
  localparam int TMO = 200;
`ifdef UART_REPORT_CRLF_EN
  localparam int MSG_LEN = 10;
`else
  localparam int MSG_LEN = 9;
`endif

  logic       clk = 1'b0, reset = 1'b1, report_req = 1'b0;
  logic [7:0] hour_bcd = 8'h00, min_bcd = 8'h00, sec_bcd = 8'h00;
  logic       tx_busy, tx_done, tx_start, rpt_busy, rpt_done, rpt_err;
  logic [7:0] tx_data;
  logic       hang = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  int nbytes = 0, starts = 0, dones = 0, errs = 0, t_start = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic       busy_p = 1'b0, start_p = 1'b0;
  logic [7:0] h_p = 8'h00, m_p = 8'h00, s_p = 8'h00, data_p = 8'h00;

  uart_time_reporter #(.TIMEOUT_CYC(TMO), .SEP_CHAR(8'h3A)) dut (
    .clk(clk), .reset(reset), .report_req_i(report_req),
    .hour_bcd_i(hour_bcd), .min_bcd_i(min_bcd), .sec_bcd_i(sec_bcd),
    .tx_busy_i(tx_busy), .tx_done_i(tx_done), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .rpt_busy_o(rpt_busy), .rpt_done_o(rpt_done), .rpt_err_o(rpt_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ASCII rendering of the time as text
  function automatic logic [7:0] ascii_digit(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'h3F;
  endfunction

  task automatic push_msg(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    int v[3];
    v[0] = int'(h); v[1] = int'(m); v[2] = int'(s);
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(ascii_digit(v[f] / 16));
      exp_q.push_back(ascii_digit(v[f] % 16));
      if (f < 2) exp_q.push_back(8'h3A);
    end
    if (MSG_LEN == 10) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART_tx responder: busy for a random bit time, tx_done across stop bit plus one cycle
  initial begin
    tx_busy = 1'b0; tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start && !reset && !hang) begin
        tx_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_busy = 1'b0;
        @(posedge clk); #1 tx_done = 1'b0;
      end
    end
  end

  // Monitor: a message start snapshots the inputs present at the accepting edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      nbytes = 0; busy_p = 1'b0; start_p = 1'b0; data_p = tx_data;
    end else begin
      if (rpt_busy && !busy_p) begin
        exp_q.delete();
        push_msg(h_p, m_p, s_p);
        nbytes = 0;
        starts++;
      end
      if (tx_start) begin
        if (exp_q.size() == 0) chk("unexpected_tx_start", 32'd1, 32'd0);
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        chk("tx_start_width", {31'd0, start_p}, 32'd0);
        sent_q.push_back(tx_data);
        nbytes++;
        t_start = cyc;
      end else begin
        chk("tx_data_hold", {24'd0, tx_data}, {24'd0, data_p});
      end
      if (rpt_done) begin
        chk("msg_len", nbytes, MSG_LEN);
        chk("bytes_left", exp_q.size(), 0);
        dones++;
      end
      if (rpt_err) begin
        chk("err_latency", cyc - t_start, TMO);
        exp_q.delete();
        errs++;
      end
      busy_p = rpt_busy; start_p = tx_start; data_p = tx_data;
    end
    h_p = hour_bcd; m_p = min_bcd; s_p = sec_bcd;
  end

  task automatic req();
    @(posedge clk); #1 report_req = 1'b1;
    @(posedge clk); #1 report_req = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(posedge clk); #1 hour_bcd = h; min_bcd = m; sec_bcd = s;
  endtask

  task automatic wait_quiet(input string name);
    int q = 0, n = 0;
    while (q < 4 && n < 20000) begin
      @(negedge clk); n++;
      if (!rpt_busy) q++; else q = 0;
    end
    if (n >= 20000) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  function automatic logic [7:0] rbcd(input int hi_max);
    return {4'($urandom_range(0, hi_max)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int d0, s0, e0, n;
    logic [7:0] ref12[10];
    ref12 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};

    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, rpt_busy}, 32'd0);
    chk("rst_done", {31'd0, rpt_done}, 32'd0);
    chk("rst_err", {31'd0, rpt_err}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // 12:34:56 with latency and literal byte sequence
    set_time(8'h12, 8'h34, 8'h56);
    sent_q.delete(); d0 = dones; s0 = starts;
    @(posedge clk); #1 report_req = 1'b1;
    @(negedge clk); chk("lat_busy_N", {31'd0, rpt_busy}, 32'd0);
    @(posedge clk); #1 report_req = 1'b0;
    @(negedge clk); chk("lat_busy_N1", {31'd0, rpt_busy}, 32'd1);
    chk("lat_start_N1", {31'd0, tx_start}, 32'd0);
    @(negedge clk); chk("lat_start_N2", {31'd0, tx_start}, 32'd1);
    wait_quiet("msg1");
    chk("msg1_count", sent_q.size(), MSG_LEN);
    if (sent_q.size() == MSG_LEN) begin
      for (int i = 0; i < 8; i++) chk($sformatf("msg1_byte%0d", i), {24'd0, sent_q[i]}, {24'd0, ref12[i]});
      if (MSG_LEN == 10) chk("msg1_cr", {24'd0, sent_q[8]}, 32'h0D);
      chk("msg1_lf", {24'd0, sent_q[MSG_LEN-1]}, 32'h0A);
    end
    chk("msg1_dones", dones - d0, 1);
    chk("msg1_starts", starts - s0, 1);

    // invalid hour nibble renders as '?'
    set_time(8'h1A, 8'h07, 8'h59);
    sent_q.delete();
    req();
    wait_quiet("badnib");
    chk("badnib_b0", {24'd0, sent_q[0]}, 32'h31);
    chk("badnib_b1", {24'd0, sent_q[1]}, 32'h3F);

    // pending: second request queued, third dropped, time moves during messages
    set_time(8'h01, 8'h02, 8'h03);
    d0 = dones; s0 = starts;
    req();
    repeat (20) @(posedge clk);
    set_time(8'h04, 8'h05, 8'h06);
    req();
    repeat (5) @(posedge clk);
    req();
    n = 0;
    while (starts - s0 < 2 && n < 5000) begin @(negedge clk); n++; end
    repeat (15) @(posedge clk);
    set_time(8'h07, 8'h08, 8'h09);
    wait_quiet("pending");
    chk("pending_dones", dones - d0, 2);
    chk("pending_starts", starts - s0, 2);

    // randomized times, including invalid nibbles and mid-message input churn
    e0 = errs;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) set_time(8'($urandom), 8'($urandom), 8'($urandom));
      else set_time(rbcd(2), rbcd(5), rbcd(5));
      req();
      repeat ($urandom_range(2, 60)) @(posedge clk);
      set_time(8'($urandom), rbcd(5), 8'($urandom));
      if ($urandom_range(0, 2) == 0) req();
      wait_quiet("random");
    end
    chk("random_errs", errs - e0, 0);

    // per-byte timeout: UART never completes; queued request is discarded by the abort
    hang = 1'b1;
    d0 = dones; s0 = starts; e0 = errs;
    req();
    repeat (10) @(posedge clk);
    req();
    n = 0;
    while (errs == e0 && n < TMO + 100) begin @(negedge clk); n++; end
    repeat (30) @(posedge clk);
    chk("tmo_errs", errs - e0, 1);
    chk("tmo_dones", dones - d0, 0);
    chk("tmo_starts", starts - s0, 1);
    chk("tmo_busy", {31'd0, rpt_busy}, 32'd0);
    hang = 1'b0;
    repeat (5) @(posedge clk);

    // reset mid-message, then a full message from index 0
    set_time(8'h23, 8'h59, 8'h58);
    d0 = dones; e0 = errs;
    req();
    n = 0;
    while (nbytes < 5 && n < 2000) begin @(negedge clk); n++; end
    chk("rst_reached_idx4", {31'd0, nbytes >= 5}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("midrst_busy", {31'd0, rpt_busy}, 32'd0);
    repeat (3) @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    chk("midrst_no_done", dones - d0, 0);
    sent_q.delete();
    req();
    wait_quiet("after_reset");
    chk("after_rst_dones", dones - d0, 1);
    chk("after_rst_errs", errs - e0, 0);
    chk("after_rst_first", {24'd0, sent_q[0]}, 32'h32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
